// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide controller: FSM states,
// op-select encodings and op classification helpers.
package hilo_muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_e;

  function automatic logic op_is_mul(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_iter.sv
// Restoring unsigned divider core (div_iter). The first quotient bit is
// resolved on the load edge, so after load plus W-1 further edges the
// quotient/remainder registers are final and done is high for one cycle.
module hilo_muldiv_ctrl_div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  logic [W-1:0]  src_rem, src_quo, src_dvs, rem_nx, quo_nx;
  logic [W:0]    shifted, trial;
  logic          fits;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    src_rem = load ? '0 : rem_q;
    src_quo = load ? dividend : quo_q;
    src_dvs = load ? divisor : dvs_q;
    shifted = {src_rem, src_quo[W-1]};
    trial   = shifted - {1'b0, src_dvs};
    fits    = ~trial[W];
    rem_nx  = fits ? trial[W-1:0] : shifted[W-1:0];
    quo_nx  = {src_quo[W-2:0], fits};
  end

  assign done      = busy_q && (cnt_q == CW'(W));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  // Iteration registers; load restarts the core even if a previous run is live.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      rem_q  <= rem_nx;
      quo_q  <= quo_nx;
      dvs_q  <= divisor;
      cnt_q  <= CW'(1);
      busy_q <= 1'b1;
    end else if (busy_q && !done) begin
      rem_q  <= rem_nx;
      quo_q  <= quo_nx;
      cnt_q  <= cnt_q + 1'b1;
    end else if (done) begin
      busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write sequencer: iterative MULT/MULTU, restoring DIV/DIVU via
// div_iter, one-cycle MTHI/MTLO moves. Stalls EX while a multi-cycle op runs.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              stall,
  output logic              hi_we,
  output logic [DATA_W-1:0] hi_data,
  output logic              lo_we,
  output logic [DATA_W-1:0] lo_data
);

  localparam int MSB = DATA_W - 1;

  state_e state_q, state_d;
  op_e    op_d;
  logic   is_mul_op, is_div_op, signed_op, accept, div_load, div_done;

  logic [DATA_W-1:0] a_mag, b_mag, quo, rem, q_fin, r_fin, a_q;
  logic              q_neg_q, r_neg_q, dz_q;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x,
                                                  input logic sgn);
    return (sgn && x[MSB]) ? -x : x;
  endfunction

  assign op_d      = op_e'(op[2:0]);
  assign is_mul_op = op_is_mul(op_d);
  assign is_div_op = op_is_div(op_d);
  assign signed_op = op_is_signed(op_d);
  assign accept    = (state_q == ST_IDLE) && start && !flush;
  assign div_load  = accept && is_div_op;
  assign a_mag     = magnitude(src_a, signed_op);
  assign b_mag     = magnitude(src_b, signed_op);

  // Divide by zero bypasses sign fix-up: LO all ones, HI the original dividend.
  assign q_fin = dz_q ? '1   : (q_neg_q ? -quo : quo);
  assign r_fin = dz_q ? a_q  : (r_neg_q ? -rem : rem);

  hilo_muldiv_ctrl_div_iter #(.W(DATA_W)) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem),
    .done      (div_done)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] prod_mag, prod_fast;
  assign prod_mag  = {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
  assign prod_fast = (signed_op && (src_a[MSB] ^ src_b[MSB])) ? -prod_mag : prod_mag;
`else
  localparam int CW = $clog2(DATA_W) + 1;
  logic [2*DATA_W-1:0] mcand_q, acc_q, acc_nx, prod_fin;
  logic [DATA_W-1:0]   mplier_q;
  logic [CW-1:0]       mcnt_q;
  logic                mul_neg_q, mul_last;

  assign acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_fin = mul_neg_q ? -acc_nx : acc_nx;
  assign mul_last = (mcnt_q == CW'(DATA_W - 1));
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and stall decode.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && is_mul_op) begin
          stall = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
          state_d = ST_DONE;
`else
          state_d = ST_MUL;
`endif
        end else if (accept && is_div_op) begin
          stall   = 1'b1;
          state_d = ST_DIV;
        end
      end
      ST_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
        state_d = ST_IDLE;
`else
        if (flush) state_d = ST_IDLE;
        else begin
          stall = 1'b1;
          if (mul_last) state_d = ST_DONE;
        end
`endif
      end
      ST_DIV: begin
        if (flush) state_d = ST_IDLE;
        else begin
          stall = 1'b1;
          if (div_done) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, multiply iteration and registered HI/LO write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_we   <= 1'b0;
      lo_we   <= 1'b0;
      hi_data <= '0;
      lo_data <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
`ifndef MULDIV_FAST_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      mcnt_q    <= '0;
      mul_neg_q <= 1'b0;
`endif
    end else begin
      hi_we <= 1'b0;
      lo_we <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (op_d)
              OP_MTHI: begin
                hi_we   <= 1'b1;
                hi_data <= src_a;
              end
              OP_MTLO: begin
                lo_we   <= 1'b1;
                lo_data <= src_a;
              end
              OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                hi_we              <= 1'b1;
                lo_we              <= 1'b1;
                {hi_data, lo_data} <= prod_fast;
`else
                mcand_q   <= {{DATA_W{1'b0}}, a_mag};
                mplier_q  <= b_mag;
                acc_q     <= '0;
                mcnt_q    <= '0;
                mul_neg_q <= signed_op & (src_a[MSB] ^ src_b[MSB]);
`endif
              end
              OP_DIV, OP_DIVU: begin
                q_neg_q <= signed_op & (src_a[MSB] ^ src_b[MSB]);
                r_neg_q <= signed_op & src_a[MSB];
                dz_q    <= (src_b == '0);
                a_q     <= src_a;
              end
              default: ;
            endcase
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        ST_MUL: begin
          if (!flush) begin
            acc_q    <= acc_nx;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            mcnt_q   <= mcnt_q + 1'b1;
            if (mul_last) begin
              hi_we              <= 1'b1;
              lo_we              <= 1'b1;
              {hi_data, lo_data} <= prod_fin;
            end
          end
        end
`endif
        ST_DIV: begin
          if (!flush && div_done) begin
            hi_we   <= 1'b1;
            lo_we   <= 1'b1;
            hi_data <= r_fin;
            lo_data <= q_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: a timeline model predicts the
// stall/write behaviour each cycle, and directed vectors pin literal results.
module tb_hilo_muldiv_ctrl;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int MUL_LAT = FAST ? 1 : 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] src_a = '0, src_b = '0;
  logic        flush = 1'b0;
  logic        stall, hi_we, lo_we;
  logic [31:0] hi_data, lo_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;

  hilo_muldiv_ctrl #(.DATA_W(32), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stall(stall), .hi_we(hi_we), .hi_data(hi_data),
    .lo_we(lo_we), .lo_data(lo_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the instruction definitions.
  function automatic void model_result(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b,
                                       output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (o)
      3'd0: begin p = 64'(sa * sb); {hi, lo} = p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (o == 3'd2) begin
          lo = 32'(sa / sb);
          hi = 32'(sa % sb);
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Timeline model: cycles left until a result write, plus a one-cycle
  // post-write window during which new starts are ignored.
  int          m_busy = 0;
  bit          m_done = 0;
  logic        e_hi_we = 0, e_lo_we = 0;
  logic [31:0] e_hi = 0, e_lo = 0, p_hi = 0, p_lo = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0;
      e_hi_we = 0; e_lo_we = 0; e_hi = 0; e_lo = 0;
    end else begin
      e_hi_we = 0;
      e_lo_we = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_busy > 0) begin
        if (flush) m_busy = 0;
        else begin
          m_busy--;
          if (m_busy == 0) begin
            e_hi_we = 1; e_lo_we = 1; e_hi = p_hi; e_lo = p_lo; m_done = 1;
          end
        end
      end else if (start && !flush) begin
        case (op)
          3'd4: begin e_hi_we = 1; e_hi = src_a; end
          3'd5: begin e_lo_we = 1; e_lo = src_a; end
          3'd0, 3'd1, 3'd2, 3'd3: begin
            model_result(op, src_a, src_b, p_hi, p_lo);
            if (FAST && op <= 3'd1) begin
              e_hi_we = 1; e_lo_we = 1; e_hi = p_hi; e_lo = p_lo; m_done = 1;
            end else m_busy = 32;
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = !rst && !m_done && !flush && ((m_busy > 0) || (start && op <= 3'd3));
    check("stall", stall, exp_stall);
    check("hi_we", hi_we, e_hi_we);
    check("lo_we", lo_we, e_lo_we);
    if (e_hi_we) check("hi_data", hi_data, e_hi);
    if (e_lo_we) check("lo_data", lo_data, e_lo);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    step();
    start = 1'b1; op = o; src_a = a; src_b = b;
    t0 = cyc;
    step();
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
  endtask

  task automatic wait_write(input string nm, input int lat, input logic ehw, input logic elw,
                            input logic [31:0] eh, input logic [31:0] el);
    bit seen = 0;
    for (int i = 0; i < 45 && !seen; i++) begin
      @(negedge clk);
      if (hi_we || lo_we) begin
        seen = 1;
        check({nm, "_latency"}, 64'(cyc - t0), 64'(lat));
        check({nm, "_hi_we"}, hi_we, ehw);
        check({nm, "_lo_we"}, lo_we, elw);
        if (ehw) check({nm, "_hi"}, hi_data, eh);
        if (elw) check({nm, "_lo"}, lo_data, el);
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no write within 45 cycles, required one", nm);
    end
  endtask

  initial begin
    int          wcount, wcyc;
    logic [31:0] wdata;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_hi_we", hi_we, 1'b0);
    check("rst_lo_we", lo_we, 1'b0);
    check("rst_hi_data", hi_data, 32'h0);
    check("rst_lo_data", lo_data, 32'h0);
    check("rst_stall", stall, 1'b0);
    step();
    rst = 1'b0;

    // Moves.
    issue(3'd4, 32'h1234_5678, 32'h0);
    wait_write("mthi", 1, 1'b1, 1'b0, 32'h1234_5678, 32'h0);

    // Multiplies; a stray MTHI mid-flight must be ignored.
    issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_write("mult_neg2x3", MUL_LAT, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    if (!FAST) begin
      step(); step();
      start = 1'b1; op = 3'd4; src_a = 32'hDEAD_BEEF;
      step();
      start = 1'b0;
    end
    wait_write("multu_max", MUL_LAT, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_write("mult_m1xm1", MUL_LAT, 1'b1, 1'b1, 32'h0, 32'h1);
    issue(3'd0, 32'h7FFF_FFFF, 32'h8000_0000);
    wait_write("mult_maxxmin", MUL_LAT, 1'b1, 1'b1, 32'hC000_0000, 32'h8000_0000);

    // Divides, including overflow and divide-by-zero.
    issue(3'd2, 32'hFFFF_FFF9, 32'h2);
    wait_write("div_m7_2", 33, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'd3, 32'h7, 32'h2);
    wait_write("divu_7_2", 33, 1'b1, 1'b1, 32'h1, 32'h3);
    issue(3'd3, 32'h64, 32'h0);
    wait_write("divu_by0", 33, 1'b1, 1'b1, 32'h64, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFFB, 32'h0);
    wait_write("div_by0", 33, 1'b1, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_write("div_ovf", 33, 1'b1, 1'b1, 32'h0, 32'h8000_0000);

    // Flush while in DONE must not cancel the write.
    issue(3'd3, 32'h1234_5678, 32'h100);
    repeat (32) step();
    flush = 1'b1;
    wait_write("divu_flush_done", 33, 1'b1, 1'b1, 32'h78, 32'h0012_3456);
    step();
    flush = 1'b0;

    // Flush in IDLE suppresses a same-cycle start.
    step();
    start = 1'b1; op = 3'd5; src_a = 32'h5555_AAAA; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_lo_we", lo_we, 1'b0);

    // Flush mid-divide at cycle 10, MTLO accepted at cycle 11.
    issue(3'd2, 32'h0000_1000, 32'h3);
    repeat (9) step();
    flush = 1'b1;
    @(negedge clk);
    check("flush_div_stall", stall, 1'b0);
    step();
    flush = 1'b0;
    start = 1'b1; op = 3'd5; src_a = 32'hCAFE_F00D;
    step();
    start = 1'b0;
    wcount = 0; wcyc = 0; wdata = '0;
    while (cyc - t0 <= 40) begin
      @(negedge clk);
      if (hi_we || lo_we) begin
        wcount++;
        wcyc  = cyc - t0;
        wdata = lo_data;
      end
    end
    check("flush_write_count", 64'(wcount), 64'd1);
    check("mtlo_after_flush_cycle", 64'(wcyc), 64'd12);
    check("mtlo_after_flush_data", wdata, 32'hCAFE_F00D);

    // Async reset mid-multiply, then a clean divide.
    issue(3'd1, 32'h0001_0001, 32'h0002_0002);
    repeat (4) step();
    rst = 1'b1;
    #1;
    check("arst_hi_we", hi_we, 1'b0);
    check("arst_lo_we", lo_we, 1'b0);
    check("arst_hi_data", hi_data, 32'h0);
    check("arst_lo_data", lo_data, 32'h0);
    check("arst_stall", stall, 1'b0);
    step(); step();
    rst = 1'b0;
    repeat (3) step();
    issue(3'd3, 32'h9, 32'h3);
    wait_write("divu_9_3", 33, 1'b1, 1'b1, 32'h0, 32'h3);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
